// File: rtl/sand_pkg.sv
// Shared types for the falling-sand simulation core.
// Tick FSM state encoding and the tick-delay width.
package sand_pkg;

    localparam int TICK_DELAY_WIDTH = 27;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        COUNT     = 2'd1,
        TICK      = 2'd2,
        WAIT_DONE = 2'd3
    } tick_state_t;

endpackage

// File: rtl/tick_generator.sv
// Generation tick source: counts to the selected delay, emits a one-cycle tick,
// then waits for the grid engine to report completion. Supports run/pause/step.
//
// Ports:
//   clk_i          system clock
//   rst_i          asynchronous reset, active-high
//   tick_delay_i   cycles per tick (floored at MIN_DELAY)
//   run_i          1 = free-run, 0 = paused
//   step_i         single-tick request while paused and idle
//   update_done_i  grid engine finished the current generation
//   tick_o         one-cycle tick pulse
//   busy_o         a tick is outstanding
//   tick_count_o   ticks issued since reset (wraps)
module tick_generator
    import sand_pkg::*;
#(
    parameter int DELAY_WIDTH = TICK_DELAY_WIDTH,
    parameter int MIN_DELAY   = 2,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [DELAY_WIDTH-1:0] tick_delay_i,
    input  logic                   run_i,
    input  logic                   step_i,
    input  logic                   update_done_i,
    output logic                   tick_o,
    output logic                   busy_o,
    output logic [COUNT_WIDTH-1:0] tick_count_o
);

    localparam logic [DELAY_WIDTH-1:0] MIN_D = DELAY_WIDTH'(MIN_DELAY);
    localparam logic [DELAY_WIDTH-1:0] TWO   = DELAY_WIDTH'(2);

    tick_state_t            r_state;
    tick_state_t            w_next;
    logic [DELAY_WIDTH-1:0] r_count;
    logic [DELAY_WIDTH-1:0] w_delay;
    logic                   w_term;
    logic                   w_tick_d;
    logic                   w_busy_d;
    logic                   r_tick;
    logic                   r_busy;
    logic [COUNT_WIDTH-1:0] r_tick_count;

    // Effective delay is re-evaluated every cycle; using >= means a delay
    // lowered below the running count fires on the next cycle instead of
    // wrapping.
    assign w_delay = (tick_delay_i < MIN_D) ? MIN_D : tick_delay_i;
    assign w_term  = (r_count >= (w_delay - TWO));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (run_i) begin
                    w_next = COUNT;
                end else if (step_i) begin
                    w_next = TICK;
                end
            end
            COUNT: begin
                if (!run_i) begin
                    w_next = IDLE;
                end else if (w_term) begin
                    w_next = TICK;
                end
            end
            TICK: begin
                if (update_done_i) begin
                    w_next = run_i ? COUNT : IDLE;
                end else begin
                    w_next = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (update_done_i) begin
                    w_next = run_i ? COUNT : IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered so they line
    // up exactly with the state they describe.
    always_comb begin
        w_tick_d = (w_next == TICK);
        w_busy_d = (w_next == TICK) || (w_next == WAIT_DONE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_count      <= '0;
            r_tick       <= 1'b0;
            r_busy       <= 1'b0;
            r_tick_count <= '0;
        end else begin
            // Counter only advances while staying in COUNT; every other
            // path (entry from IDLE/TICK/WAIT_DONE) starts from zero.
            if ((r_state == COUNT) && (w_next == COUNT)) begin
                r_count <= r_count + DELAY_WIDTH'(1);
            end else begin
                r_count <= '0;
            end
            r_tick <= w_tick_d;
            r_busy <= w_busy_d;
            if (w_tick_d) begin
                r_tick_count <= r_tick_count + COUNT_WIDTH'(1);
            end
        end
    end

    assign tick_o       = r_tick;
    assign busy_o       = r_busy;
    assign tick_count_o = r_tick_count;

endmodule

// File: tb/tb_tick_generator.sv
// Directed bench for tick_generator: per-cycle vector table plus
// multi-cycle sequences for period, latency, delay change, wrap and reset.
module tb_tick_generator;

    localparam int DW = 27;
    localparam int CW = 8;

    logic          clk;
    logic          rst;
    logic [DW-1:0] dly;
    logic          run;
    logic          step;
    logic          done;
    logic          tick;
    logic          busy;
    logic [CW-1:0] tcnt;

    int            n_total;
    int            n_bad;
    logic [CW-1:0] exp_cnt;
    bit            saw_zero;

    tick_generator #(
        .DELAY_WIDTH (DW),
        .MIN_DELAY   (2),
        .COUNT_WIDTH (CW)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .tick_delay_i  (dly),
        .run_i         (run),
        .step_i        (step),
        .update_done_i (done),
        .tick_o        (tick),
        .busy_o        (busy),
        .tick_count_o  (tcnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          r;
        logic          s;
        logic          dn;
        logic          e_tick;
        logic          e_busy;
        logic [CW-1:0] e_cnt;
    } vec_t;

    vec_t vt [18];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        run  = 1'b0;
        step = 1'b0;
        done = 1'b0;
        @(posedge clk);
        #1;
        rst     = 1'b0;
        exp_cnt = '0;
    endtask

    // Runs ncyc cycles with done returned lat cycles after each tick.
    // Checks first tick position, inter-tick period, busy length, count.
    task automatic run_seq(input string nm, input int ncyc, input int lat,
                           input bit extra, input int per, input int first_at,
                           output int nt);
        int last;
        int cd;
        int busyc;
        last  = -1;
        cd    = -1;
        busyc = 0;
        nt    = 0;
        for (int c = 1; c <= ncyc; c++) begin
            @(posedge clk);
            #1;
            if (tick) begin
                exp_cnt++;
                nt++;
                chk({nm, " cnt"}, 32'(tcnt), 32'(exp_cnt));
                if (tcnt == '0) saw_zero = 1'b1;
                if (last < 0) begin
                    chk({nm, " first"}, c, first_at);
                end else begin
                    chk({nm, " period"}, c - last, per);
                    chk({nm, " busylen"}, busyc, lat + 1);
                end
                last  = c;
                cd    = lat;
                busyc = 0;
            end
            if (busy) busyc++;
            if (cd == 0) begin
                done = 1'b1;
                cd   = -1;
            end else begin
                if (cd > 0) cd--;
                done = extra && !busy && (c % 3 == 0);
            end
        end
        done = 1'b0;
    endtask

    initial begin : watchdog
        #5ms;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin : main
        int  nt;
        bit  quiet;
        n_total  = 0;
        n_bad    = 0;
        saw_zero = 1'b0;
        dly      = '0;

        //          dly     run   step  done  tick  busy  cnt
        vt[0]  = '{27'd10, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'd1};
        vt[1]  = '{27'd10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1};
        vt[2]  = '{27'd10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1};
        vt[3]  = '{27'd10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1};
        vt[4]  = '{27'd10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
        vt[5]  = '{27'd10, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'd2};
        vt[6]  = '{27'd10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd2};
        vt[7]  = '{27'd10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd2};
        vt[8]  = '{27'd0,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd2};
        vt[9]  = '{27'd0,  1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'd3};
        vt[10] = '{27'd0,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd3};
        vt[11] = '{27'd0,  1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'd4};
        vt[12] = '{27'd1,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd4};
        vt[13] = '{27'd1,  1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'd5};
        vt[14] = '{27'd1,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd5};
        vt[15] = '{27'd5,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd5};
        vt[16] = '{27'd5,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd5};
        vt[17] = '{27'd5,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd5};

        do_reset();
        chk("rst tick", 32'(tick), 0);
        chk("rst busy", 32'(busy), 0);
        chk("rst cnt", 32'(tcnt), 0);

        // step / clamp / pause vectors
        for (int i = 0; i < 18; i++) begin
            dly  = vt[i].d;
            run  = vt[i].r;
            step = vt[i].s;
            done = vt[i].dn;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d tick", i), 32'(tick), 32'(vt[i].e_tick));
            chk($sformatf("vec%0d busy", i), 32'(busy), 32'(vt[i].e_busy));
            chk($sformatf("vec%0d cnt", i), 32'(tcnt), 32'(vt[i].e_cnt));
        end

        // reset mid-COUNT after one tick, then reset during TICK
        do_reset();
        dly  = 27'd10;
        run  = 1'b1;
        done = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        chk("pre-rst cnt", 32'(tcnt), 1);
        #1 rst = 1'b1;
        #1;
        chk("async rst cnt", 32'(tcnt), 0);
        chk("async rst busy", 32'(busy), 0);
        run = 1'b0;
        @(posedge clk);
        #1;
        chk("held rst tick", 32'(tick), 0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("post-rst idle tick", 32'(tick), 0);
        run = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("pre-rst tick", 32'(tick), 1);
        #1 rst = 1'b1;
        #1;
        chk("rst in tick", 32'(tick), 0);
        chk("rst in tick busy", 32'(busy), 0);

        // period 10, done in TICK cycle
        do_reset();
        dly = 27'd10;
        run = 1'b1;
        run_seq("p10", 35, 0, 1'b0, 10, 10, nt);
        chk("p10 ticks", nt, 3);

        // clamped delays
        do_reset();
        dly = 27'd0;
        run = 1'b1;
        run_seq("d0", 20, 0, 1'b0, 2, 2, nt);
        chk("d0 ticks", nt, 10);
        do_reset();
        dly = 27'd1;
        run = 1'b1;
        run_seq("d1", 20, 0, 1'b0, 2, 2, nt);
        chk("d1 ticks", nt, 10);

        // done latency 5, stray done pulses while counting
        do_reset();
        dly = 27'd10;
        run = 1'b1;
        run_seq("lat5", 50, 5, 1'b1, 15, 10, nt);
        chk("lat5 ticks", nt, 3);

        // delay lowered below running count
        do_reset();
        dly   = 27'd1000;
        run   = 1'b1;
        quiet = 1'b1;
        repeat (501) begin
            @(posedge clk);
            #1;
            if (tick) quiet = 1'b0;
        end
        chk("d1000 no early tick", 32'(quiet), 1);
        dly = 27'd100;
        @(posedge clk);
        #1;
        chk("lowered tick", 32'(tick), 1);
        exp_cnt++;
        chk("lowered cnt", 32'(tcnt), 32'(exp_cnt));
        done = 1'b1;
        run_seq("p100", 250, 0, 1'b0, 100, 100, nt);
        chk("p100 ticks", nt, 2);

        // count wraps
        do_reset();
        saw_zero = 1'b0;
        dly      = 27'd2;
        run      = 1'b1;
        run_seq("wrap", 600, 0, 1'b0, 2, 2, nt);
        chk("wrap ticks", nt, 300);
        chk("wrap to zero", 32'(saw_zero), 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
